// File: rtl/queue14_arb.sv
// rtl/queue14_arb.sv - round-robin write arbiter and occupancy controller for a 64-slot, 14-bit queue
module queue14_arb #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [14*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   grant,
    input  logic              pop,
    output logic              valid,
    input  logic              flush,
    output logic [13:0]       q_din,
    output logic              q_wr_en,
    output logic              q_rd_en,
    output logic              q_rst,
    output logic [5:0]        count,
    output logic              full,
    output logic [5:0]        hwm
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] grant_idx;
    logic          any_grant;
    logic          rst_hold;
    logic [5:0]    count_next;
    logic [5:0]    hwm_next;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // The queue never reports full itself, so occupancy 63 is the hard write stop.
    assign full    = (count == 6'd63);
    assign q_rst   = flush | rst | rst_hold;
    assign valid   = (count != 6'd0) && !q_rst;
    assign q_rd_en = pop & valid & ~flush;
    assign q_wr_en = any_grant;

    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        if (!(full || q_rst)) begin
            for (int off = 0; off < NREQ; off++) begin
                if (!any_grant && req[wrap_idx(ptr, off)]) begin
                    any_grant = 1'b1;
                    grant_idx = wrap_idx(ptr, off);
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any_grant) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        q_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) q_din = wdata[14*i +: 14];
        end
    end

    assign ptr_next = any_grant ? wrap_idx(grant_idx, 1) : ptr;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({q_wr_en, q_rd_en})
                2'b10:   count_next = count + 6'd1;
                2'b01:   count_next = count - 6'd1;
                default: count_next = count;
            endcase
        end
    end

    always_comb begin
        hwm_next = hwm;
        if (flush)                 hwm_next = '0;
        else if (count_next > hwm) hwm_next = count_next;
    end

    // rst_hold stretches q_rst so the queue sees a synchronous reset edge after rst releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            hwm      <= '0;
            ptr      <= '0;
            rst_hold <= 1'b1;
        end else begin
            count    <= count_next;
            hwm      <= hwm_next;
            ptr      <= ptr_next;
            rst_hold <= 1'b0;
        end
    end

endmodule

// File: tb/tb_queue14_arb.sv
// tb/tb_queue14_arb.sv - randomized and directed checks of queue14_arb against a FIFO-level model
module tb_queue14_arb;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [14*N-1:0]  wdata;
    logic [N-1:0]     grant;
    logic             pop;
    logic             valid;
    logic             flush;
    logic [13:0]      q_din;
    logic             q_wr_en;
    logic             q_rd_en;
    logic             q_rst;
    logic [5:0]       count;
    logic             full;
    logic [5:0]       hwm;

    logic [13:0]      wd [N];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) wdata[14*i +: 14] = wd[i];
    end

    queue14_arb #(.NREQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .grant(grant),
        .pop(pop), .valid(valid), .flush(flush), .q_din(q_din),
        .q_wr_en(q_wr_en), .q_rd_en(q_rd_en), .q_rst(q_rst),
        .count(count), .full(full), .hwm(hwm)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference: a FIFO of accepted words plus round-robin pointer and high-water mark
    logic [13:0] m_fifo [$];
    int          m_ptr  = 0;
    int          m_hwm  = 0;
    bit          m_hold = 1'b1;
    bit          auto_mode = 1'b0;

    // bench-side copy of the queue storage, driven only by the DUT strobes
    logic [13:0] ram [64];
    logic [5:0]  wp = '0;
    logic [5:0]  rp = '0;

    int          o_k;
    logic [N-1:0] o_grant;
    logic        o_wr, o_rd, o_qrst;
    logic [13:0] o_din;
    logic [5:0]  o_count;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int oh2i(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        int k;
        int cnt;
        bit e_qrst, e_full, e_valid, e_rd;
        logic [N-1:0] e_grant;
        logic [13:0]  e_din;
        #1;
        if (rst) begin
            m_ptr = 0; m_hwm = 0; m_fifo.delete(); m_hold = 1'b1;
        end
        cnt     = m_fifo.size();
        e_qrst  = flush | rst | m_hold;
        e_full  = (cnt == 63);
        e_valid = (cnt != 0) && !e_qrst;
        k = -1;
        if (!e_full && !e_qrst) begin
            for (int off = 0; off < N; off++)
                if (k < 0 && req[(m_ptr + off) % N]) k = (m_ptr + off) % N;
        end
        e_grant = '0;
        e_din   = '0;
        if (k >= 0) begin
            e_grant[k] = 1'b1;
            e_din      = wd[k];
        end
        e_rd = pop && e_valid && !flush;

        check("grant",   grant,   e_grant);
        check("q_din",   q_din,   e_din);
        check("q_wr_en", q_wr_en, (k >= 0) ? 1 : 0);
        check("q_rd_en", q_rd_en, e_rd);
        check("q_rst",   q_rst,   e_qrst);
        check("valid",   valid,   e_valid);
        check("full",    full,    e_full);
        check("count",   count,   cnt);
        check("hwm",     hwm,     m_hwm);
        if (e_rd && q_rd_en) check("dout", ram[rp], m_fifo[0]);

        o_grant = grant; o_k = oh2i(grant); o_wr = q_wr_en; o_rd = q_rd_en;
        o_qrst = q_rst; o_din = q_din; o_count = count;

        @(posedge clk);
        if (o_qrst) begin
            wp = '0; rp = '0;
        end else begin
            if (o_wr) begin ram[wp] = o_din; wp = wp + 6'd1; end
            if (o_rd) rp = rp + 6'd1;
        end
        if (!rst) begin
            if (flush) begin
                m_fifo.delete(); m_hwm = 0;
            end else begin
                if (e_rd) void'(m_fifo.pop_front());
                if (k >= 0) begin
                    m_fifo.push_back(wd[k]);
                    m_ptr = (k + 1) % N;
                end
            end
        end
        if (m_fifo.size() > m_hwm) m_hwm = m_fifo.size();
        m_hold = rst;

        @(negedge clk);
        if (k >= 0) wd[k] = 14'($urandom);
        if (auto_mode) begin
            if (k >= 0 && $urandom_range(1) == 1) req[k] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
        end
    endtask

    initial begin
        int nw, late;
        rst = 1'b1; req = '0; pop = 1'b0; flush = 1'b0;
        for (int i = 0; i < N; i++) wd[i] = 14'($urandom);
        @(negedge clk);
        step();
        check("init_qrst", o_qrst, 1);
        rst = 1'b0;
        step();
        check("rel_hold", o_qrst, 1);
        step();
        check("rel_done", o_qrst, 0);

        req = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fair", o_k, i % 4);
        end
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("solo", o_k, 2);
        end

        req = '0; pop = 1'b1;
        for (int i = 0; i < 80 && count != 0; i++) step();
        check("drained", count, 0);

        req = 4'b0001; pop = 1'b0; nw = 0; late = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (o_wr) nw++;
            if (i >= 63 && o_grant != 0) late++;
        end
        check("fill_writes", nw, 63);
        check("late_grants", late, 0);
        check("fill_full", full, 1);
        check("fill_count", count, 63);
        check("fill_hwm", hwm, 63);

        req = '1; pop = 1'b1;
        step();
        check("full_rd", o_rd, 1);
        check("full_gnt", o_grant, 0);
        check("full_pop_cnt", count, 62);

        req = '0;
        for (int i = 0; i < 80 && count != 0; i++) step();
        step();
        check("empty_rd", o_rd, 0);
        check("empty_cnt", count, 0);

        req = 4'b0010; pop = 1'b0;
        for (int i = 0; i < 20 && count != 5; i++) step();
        pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rw_cnt", count, 5);
        end

        req = '0; pop = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 40 && count != 20; i++) step();
        check("pre_flush_hwm", hwm, 20);
        req = 4'b1000; pop = 1'b1; flush = 1'b1;
        step();
        check("flush_gnt", o_grant, 0);
        check("flush_rd", o_rd, 0);
        check("flush_qrst", o_qrst, 1);
        flush = 1'b0; req = '0; pop = 1'b0;
        #1;
        check("flush_cnt", count, 0);
        check("flush_hwm", hwm, 0);
        check("flush_valid", valid, 0);
        @(negedge clk);
        req = '1;
        step();
        check("ptr_kept", o_k, 1);

        req = 4'b0001;
        for (int i = 0; i < 20 && count != 10; i++) step();
        rst = 1'b1; pop = 1'b1;
        step();
        check("rst_cnt", o_count, 0);
        check("rst_gnt", o_grant, 0);
        check("rst_qrst", o_qrst, 1);
        rst = 1'b0;
        step();
        check("rst_hold", o_qrst, 1);
        check("rst_hold_cnt", o_count, 0);
        step();
        check("rst_done", o_qrst, 0);

        auto_mode = 1'b1;
        for (int blk = 0; blk < 15; blk++) begin
            int pp;
            pp = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 80);
            for (int i = 0; i < 200; i++) begin
                pop   = ($urandom_range(99) < pp);
                flush = ($urandom_range(59) == 0);
                rst   = ($urandom_range(249) == 0);
                step();
            end
        end
        rst = 1'b0; flush = 1'b0; pop = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
